xalu_nibble_sequencer: RTL and testbench
========================================

Name: xalu_nibble_sequencer

Overview:
Sequential driver for the 4-bit ALU slice: the other end of the slice's operand, function, carry and status pins. Runs one wide operation (4*NIBBLES bits) as NIBBLES back-to-back slice passes, one nibble per clock. Feeds each nibble's carry output into the next nibble's carry input, assembles the wide result, and reduces the per-nibble status flags into wide flags. Sits between a host or register file and one external or on-die slice instance.

Parameters:
NIBBLES, 4, number of 4-bit slice passes per operation (operand width = 4*NIBBLES); legal range 2..8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; accepted only in IDLE
func  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
com  in  1  ones-complement output mode, passed to slice
cin  in  1  carry/shift-in for the first pass
op_a  in  4*NIBBLES  operand A
op_b  in  4*NIBBLES  operand B
alu_a  out  4  slice port A nibble
alu_b  out  4  slice port B nibble
alu_f  out  3  slice function code
alu_com  out  1  slice complement mode
alu_ci_right  out  1  slice right carry input
alu_ci_left  out  1  slice left carry input
alu_d  in  4  slice result nibble
alu_co_left  in  1  slice left carry output
alu_co_right  in  1  slice right carry output
alu_zero  in  1  slice +zero flag
alu_neg_zero  in  1  slice -zero flag
alu_equ  in  1  slice A=B flag
result  out  4*NIBBLES  assembled result
carry_out  out  1  final carry/shift-out
zero  out  1  result all zeros
neg_zero  out  1  result all ones
equal  out  1  op_a == op_b
busy  out  1  high in RUN
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, nibble index 0, all outputs 0. Reset during RUN aborts the operation: no done, result cleared.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on start=1 at edge k, latch op_a, op_b, func, com and cin; go to RUN. Index starts at 0.
- RUN lasts exactly NIBBLES cycles (k+1..k+NIBBLES). busy=1.
- Slice treated as purely combinational: drive the nibble and sample the alu_* inputs in the same cycle.
- Pass order:
  - SHR (6): MSB nibble first. ci_left of the first pass = latched cin; each later pass gets ci_left = previous alu_co_right; ci_right = 0.
  - All other codes: LSB nibble first. ci_right of the first pass = latched cin; each later pass gets ci_right = previous alu_co_left; ci_left = 0.
- Capture per pass:
  - alu_d is written into its nibble position of result.
  - zero, neg_zero and equal are the running AND of alu_zero, alu_neg_zero and alu_equ (each initialised to 1 at start).
- carry_out = alu_co_left of the final pass, or alu_co_right of the final pass for SHR. The slice forces it to 0 for logic and pass codes.
- com is passed through only. The slice applies inversion to data only; carries are not inverted.
- DONE: one cycle with done=1 and busy=0 at cycle k+NIBBLES+1, then IDLE. Latency start-to-done = NIBBLES+1 cycles.
- result and flags hold from DONE until the next accepted start. On start they are cleared at edge k.
- Outside RUN: alu_a, alu_b, alu_f, alu_com and alu_ci_* are driven 0.
- start while busy or in the DONE cycle is ignored; no queueing.
- Operand inputs may change freely after edge k.

Decomposition:
- Package xalu_pkg holds:
  - function-code localparams F_ADD..F_SHL (3 bits);
  - state enum IDLE/RUN/DONE;
  - nibble-width constant 4.
- No RTL sub-module: the nibble mux/demux stays inline.
- The bench supplies a behavioural model of the 4-bit slice, wired back onto the alu_* ports.

Test Plan:
- NIBBLES=4, ADD, 0x0FFF+0x0001, cin=0, com=0 -> result 0x1000, carry_out 0, zero 0, done exactly 5 cycles after start.
- ADD 0xFFFF+0x0001, cin=0 -> result 0x0000, carry_out 1, zero 1, neg_zero 0, equal 0.
- SHL 0x8001, cin=1 -> result 0x0003, carry_out 1. SHR 0x8001, cin=0 -> result 0x4000, carry_out 1; first pass alu_a=0x8.
- XOR 0x1234^0x1234, com=1 -> result 0xFFFF, neg_zero 1, zero 0, equal 1.
- Sequencing:
  - start pulsed again during RUN with different operands -> ignored; first result unchanged; single done.
  - rst_n low at cycle k+2 -> no done, busy 0, result 0x0000.
  - a new start afterwards completes normally.

Source files
------------

// File: rtl/xalu_nibble_sequencer_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: slice function codes,
// sequencer states and the slice data width.
package xalu_pkg;
    localparam int NW = 4;

    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_AND   = 3'd1;
    localparam logic [2:0] F_OR    = 3'd2;
    localparam logic [2:0] F_XOR   = 3'd3;
    localparam logic [2:0] F_PASSA = 3'd4;
    localparam logic [2:0] F_PASSB = 3'd5;
    localparam logic [2:0] F_SHR   = 3'd6;
    localparam logic [2:0] F_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/xalu_nibble_sequencer_if.sv
// Pin bundle between the sequencer (master) and one 4-bit ALU slice (slave).
interface xalu_nibble_sequencer_if;
    import xalu_pkg::*;

    logic [NW-1:0] alu_a;
    logic [NW-1:0] alu_b;
    logic [2:0]    alu_f;
    logic          alu_com;
    logic          alu_ci_right;
    logic          alu_ci_left;
    logic [NW-1:0] alu_d;
    logic          alu_co_left;
    logic          alu_co_right;
    logic          alu_zero;
    logic          alu_neg_zero;
    logic          alu_equ;

    modport master (
        output alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
        input  alu_d, alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ
    );

    modport slave (
        input  alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
        output alu_d, alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ
    );
endinterface

// File: rtl/xalu_nibble_sequencer.sv
// Runs one 4*NIBBLES-bit operation as NIBBLES passes through a combinational
// 4-bit slice, chaining carries and AND-reducing the per-nibble status flags.
module xalu_nibble_sequencer
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              func,
    input  logic                    com,
    input  logic                    cin,
    input  logic [NW*NIBBLES-1:0]   op_a,
    input  logic [NW*NIBBLES-1:0]   op_b,
    xalu_nibble_sequencer_if.master alu,
    output logic [NW*NIBBLES-1:0]   result,
    output logic                    carry_out,
    output logic                    zero,
    output logic                    neg_zero,
    output logic                    equal,
    output logic                    busy,
    output logic                    done
);
    localparam int W     = NW * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, pos;
    logic [W-1:0]     a_q, b_q;
    logic [2:0]       f_q;
    logic             com_q, chain_q;
    logic             is_shr, last, co_sel;

    assign is_shr = (f_q == F_SHR);
    assign last   = (idx == LAST_IDX);
    // Shift-right walks MSB nibble first so the shift-in ripples downward.
    assign pos    = is_shr ? (LAST_IDX - idx) : idx;
    assign co_sel = is_shr ? alu.alu_co_right : alu.alu_co_left;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt        = state;
        alu.alu_a        = '0;
        alu.alu_b        = '0;
        alu.alu_f        = '0;
        alu.alu_com      = 1'b0;
        alu.alu_ci_right = 1'b0;
        alu.alu_ci_left  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                alu.alu_a   = a_q[pos*NW +: NW];
                alu.alu_b   = b_q[pos*NW +: NW];
                alu.alu_f   = f_q;
                alu.alu_com = com_q;
                if (is_shr) alu.alu_ci_left  = chain_q;
                else        alu.alu_ci_right = chain_q;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            com_q     <= 1'b0;
            chain_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            neg_zero  <= 1'b0;
            equal     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    a_q       <= op_a;
                    b_q       <= op_b;
                    f_q       <= func;
                    com_q     <= com;
                    chain_q   <= cin;
                    idx       <= '0;
                    result    <= '0;
                    carry_out <= 1'b0;
                    zero      <= 1'b1;
                    neg_zero  <= 1'b1;
                    equal     <= 1'b1;
                end
                RUN: begin
                    result[pos*NW +: NW] <= alu.alu_d;
                    zero      <= zero & alu.alu_zero;
                    neg_zero  <= neg_zero & alu.alu_neg_zero;
                    equal     <= equal & alu.alu_equ;
                    chain_q   <= co_sel;
                    carry_out <= co_sel;
                    idx       <= last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// Directed bench: behavioural 4-bit slice on the alu_* pins, hand-computed
// wide results, carries, flags and handshake timing.
module tb_xalu_nibble_sequencer;
    import xalu_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n, start, com, cin;
    logic [2:0]   func;
    logic [W-1:0] op_a, op_b, result;
    logic         carry_out, zero, neg_zero, equal, busy, done;
    int           checks = 0;
    int           failures = 0;

    xalu_nibble_sequencer_if sif ();

    xalu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .com(com), .cin(cin),
        .op_a(op_a), .op_b(op_b), .alu(sif.slave), .result(result),
        .carry_out(carry_out), .zero(zero), .neg_zero(neg_zero), .equal(equal),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Slice model: carries are not affected by complement mode.
    logic [4:0] sum;
    logic [3:0] d_raw;
    always_comb begin
        sum              = {1'b0, sif.alu_a} + {1'b0, sif.alu_b} + {4'd0, sif.alu_ci_right};
        d_raw            = 4'd0;
        sif.alu_co_left  = 1'b0;
        sif.alu_co_right = 1'b0;
        case (sif.alu_f)
            F_ADD:   begin d_raw = sum[3:0]; sif.alu_co_left = sum[4]; end
            F_AND:   d_raw = sif.alu_a & sif.alu_b;
            F_OR:    d_raw = sif.alu_a | sif.alu_b;
            F_XOR:   d_raw = sif.alu_a ^ sif.alu_b;
            F_PASSA: d_raw = sif.alu_a;
            F_PASSB: d_raw = sif.alu_b;
            F_SHR:   begin d_raw = {sif.alu_ci_left, sif.alu_a[3:1]}; sif.alu_co_right = sif.alu_a[0]; end
            F_SHL:   begin d_raw = {sif.alu_a[2:0], sif.alu_ci_right}; sif.alu_co_left = sif.alu_a[3]; end
            default: d_raw = 4'd0;
        endcase
        sif.alu_d        = sif.alu_com ? ~d_raw : d_raw;
        sif.alu_zero     = (sif.alu_d == 4'h0);
        sif.alu_neg_zero = (sif.alu_d == 4'hF);
        sif.alu_equ      = (sif.alu_a == sif.alu_b);
    end

    // Issues one operation, scrambles the inputs afterwards, returns the
    // negedge count from the start edge to done (0 on timeout).
    task automatic run_op(input logic [2:0] f, input logic c, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [3:0] first_a);
        @(negedge clk);
        func = f; com = c; cin = ci; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; func = F_PASSB; com = ~c; cin = ~ci;
        lat = 0; first_a = 4'd0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) first_a = sif.alu_a;
            if (done) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (result !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0 ||
            zero !== 1'b0 || sif.alu_a !== 4'h0 || sif.alu_f !== 3'h0) begin
            failures++;
            $display("FAIL reset_state got result=%h busy=%b done=%b co=%b zero=%b alu_a=%h alu_f=%h exp all 0",
                     result, busy, done, carry_out, zero, sif.alu_a, sif.alu_f);
        end
    endtask

    task automatic test_add();
        int lat; logic [3:0] fa;
        run_op(F_ADD, 1'b0, 1'b0, 16'h0FFF, 16'h0001, lat, fa);
        checks++; if (lat !== 5) begin failures++; $display("FAIL add_latency got=%0d exp=5", lat); end
        checks++; if (result !== 16'h1000) begin failures++; $display("FAIL add_result got=%h exp=1000", result); end
        checks++; if (carry_out !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL add_flags got co=%b zero=%b exp co=0 zero=0", carry_out, zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_in_done got=%b exp=0", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'h1000 || sif.alu_f !== 3'd0 || sif.alu_a !== 4'd0) begin
            failures++;
            $display("FAIL add_hold got done=%b result=%h alu_f=%h alu_a=%h exp 0 1000 0 0", done, result, sif.alu_f, sif.alu_a);
        end
    endtask

    task automatic test_add_wrap();
        int lat; logic [3:0] fa;
        run_op(F_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, lat, fa);
        checks++; if (result !== 16'h0000) begin failures++; $display("FAIL wrap_result got=%h exp=0000", result); end
        checks++;
        if (carry_out !== 1'b1 || zero !== 1'b1 || neg_zero !== 1'b0 || equal !== 1'b0) begin
            failures++;
            $display("FAIL wrap_flags got co=%b z=%b nz=%b eq=%b exp 1 1 0 0", carry_out, zero, neg_zero, equal);
        end
    endtask

    task automatic test_shift();
        int lat; logic [3:0] fa;
        run_op(F_SHL, 1'b0, 1'b1, 16'h8001, 16'h0000, lat, fa);
        checks++; if (result !== 16'h0003 || carry_out !== 1'b1) begin failures++; $display("FAIL shl got result=%h co=%b exp 0003 1", result, carry_out); end
        checks++; if (fa !== 4'h1) begin failures++; $display("FAIL shl_first_nibble got=%h exp=1", fa); end
        run_op(F_SHR, 1'b0, 1'b0, 16'h8001, 16'h0000, lat, fa);
        checks++; if (result !== 16'h4000 || carry_out !== 1'b1) begin failures++; $display("FAIL shr got result=%h co=%b exp 4000 1", result, carry_out); end
        checks++; if (fa !== 4'h8) begin failures++; $display("FAIL shr_first_nibble got=%h exp=8", fa); end
        checks++; if (lat !== 5) begin failures++; $display("FAIL shr_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_xor_com();
        int lat; logic [3:0] fa;
        run_op(F_XOR, 1'b1, 1'b0, 16'h1234, 16'h1234, lat, fa);
        checks++; if (result !== 16'hFFFF) begin failures++; $display("FAIL xor_com_result got=%h exp=ffff", result); end
        checks++;
        if (neg_zero !== 1'b1 || zero !== 1'b0 || equal !== 1'b1 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL xor_com_flags got nz=%b z=%b eq=%b co=%b exp 1 0 1 0", neg_zero, zero, equal, carry_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, dcnt;
        @(negedge clk);
        func = F_ADD; com = 1'b0; cin = 1'b0; op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; dcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 2) begin start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; func = F_OR; end
            else start = done;
            if (done) begin dcnt++; if (lat == 0) lat = n; end
        end
        start = 1'b0;
        checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        checks++; if (dcnt !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", dcnt); end
        checks++; if (result !== 16'h3333 || busy !== 1'b0) begin failures++; $display("FAIL b2b_result got=%h busy=%b exp 3333 0", result, busy); end
    endtask

    task automatic test_reset_abort();
        int dcnt, lat; logic [3:0] fa;
        @(negedge clk);
        func = F_ADD; com = 1'b0; cin = 1'b0; op_a = 16'h1234; op_b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || result !== 16'h0) begin failures++; $display("FAIL abort_state got busy=%b result=%h exp 0 0000", busy, result); end
        dcnt = 0;
        for (int n = 0; n < 8; n++) begin @(negedge clk); if (done) dcnt++; end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL abort_done_count got=%0d exp=0", dcnt); end
        run_op(F_ADD, 1'b0, 1'b0, 16'h0005, 16'h0003, lat, fa);
        checks++; if (lat !== 5 || result !== 16'h0008) begin failures++; $display("FAIL after_abort got lat=%0d result=%h exp 5 0008", lat, result); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; func = 3'd0; com = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_add();
        test_add_wrap();
        test_shift();
        test_xor_com();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
